awg_sweep_sequencer: RTL and testbench
======================================

# awg_sweep_sequencer

Frequency-sweep scheduler for the AWG. Sits between `Control_Logic` and `Waveform_Generator`:
- Owns the `frequency` input of the generator.
- When idle, passes the manually configured frequency through.
- When started, steps the frequency from a start value toward a stop value, holding each point for a programmed dwell.
- Sweep shapes: single-shot, repeating sawtooth, or triangle.

## Interface
Parameters:
- `FREQ_W`, 16: frequency word width (matches generator `frequency`).
- `DWELL_W`, 16: dwell counter width.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `cfg_valid`  in  1: config write strobe.
- `cfg_ready`  out  1: high only in IDLE; a config is accepted when `cfg_valid & cfg_ready`.
- `cfg_start`  in  FREQ_W: first sweep point.
- `cfg_stop`  in  FREQ_W: upper sweep bound.
- `cfg_step`  in  FREQ_W: increment per point.
- `cfg_dwell`  in  DWELL_W: hold length; each point is held `cfg_dwell+1` cycles.
- `cfg_mode`  in  2: 0 single, 1 repeat, 2 triangle, 3 reserved (treated as single).
- `start`  in  1: one-cycle sweep start pulse.
- `abort`  in  1: one-cycle sweep abort pulse.
- `manual_freq`  in  FREQ_W: frequency output in IDLE.
- `frequency`  out  FREQ_W: to `Waveform_Generator`.
- `freq_update`  out  1: one-cycle pulse coincident with every change of `frequency` caused by a sweep event (load, step, restart, end, abort).
- `busy`  out  1: high outside IDLE.
- `done`  out  1: one-cycle pulse at natural sweep end (single mode only).
- `cfg_err`  out  1: one-cycle pulse when `start` is rejected.
- `dir_down`  out  1: current triangle direction.

## Operation
- **Reset values:** state IDLE; stored config all zero; `frequency=0` during reset, then tracks `manual_freq` registered; all other outputs 0.
- **States:** IDLE, DWELL, STEP.
- **IDLE:**
  - `frequency <= manual_freq` every cycle.
  - A config handshake stores all `cfg_*` fields.
  - `start` is accepted only if `start <= stop` and `step != 0`. Otherwise `cfg_err` pulses and the block stays in IDLE.
  - If `cfg_valid` and `start` arrive in the same cycle, the new config is validated and used.
- **Accepted start:** `frequency <= cfg_start`, `freq_update`, dwell counter loaded with `cfg_dwell`, `dir_down=0`, go to DWELL.
- **DWELL:** counter decrements each cycle. When it reads 0, go to STEP.
- **STEP:** evaluated in a single cycle, using (FREQ_W+1)-bit arithmetic so overflow and underflow never wrap.
  - Up, `freq+step <= stop`: load `freq+step`.
  - Up, exceeds stop:
    - Single: `done`, return to IDLE, `frequency <= manual_freq`, `freq_update`.
    - Repeat: load `cfg_start`.
    - Triangle: set `dir_down=1` and apply the down rule.
  - Down, `freq-step >= start`: load `freq-step`.
  - Down, below start: set `dir_down=0` and apply the up rule.
  - Triangle with `start==stop`, or with `step > stop-start`: both directions fail, so the frequency is reloaded unchanged and `freq_update` still pulses.
  - Every load reloads the dwell counter and returns to DWELL.
- **`abort`:** in any non-IDLE state, go to IDLE on the next edge with `frequency <= manual_freq` and `freq_update`; no `done`. `abort` has priority over a same-cycle step or done.
- **Ignored inputs:** `start` while busy; `cfg_valid` while busy (`cfg_ready=0`).
- **`rst` mid-sweep:** immediate return to reset values; stored config is cleared.

## Timing
- Start to first point: `frequency` equals `cfg_start` on the cycle after the `start` edge.
- Each sweep point is visible for exactly `cfg_dwell+1` cycles, with DWELL and STEP cycles included.
- `freq_update` is registered and aligned with the new `frequency`.
- `done` is aligned with the return to `manual_freq`.
- Abort latency is 1 cycle.
- `manual_freq` is seen at the output 1 cycle after it changes (IDLE only).

## Structure
- `awg_pkg` holds:
  - mode constants `MODE_SINGLE`/`MODE_REPEAT`/`MODE_TRIANGLE`;
  - the state encoding;
  - default widths, shared with `Control_Logic` and `Waveform_Generator`.
- One sub-module, `awg_dwell_timer`: a loadable down-counter with a `load`/`value`/`expired` interface.
- The next-frequency compare/add/subtract logic stays inline.

## Test plan
- **Single sweep:** cfg start=100, stop=130, step=10, dwell=2, mode 0. Expect `frequency` 100,100,100,110×3,120×3,130×3; then `done` and a return to `manual_freq`; 4 `freq_update` pulses plus one at end.
- **Repeat:** cfg start=0, stop=20, step=10, dwell=0, mode 1. Expect sequence 0,10,20,0,10,… with `busy` held; then `abort` returns `manual_freq` within 1 cycle, with no `done`.
- **Triangle:** cfg start=10, stop=30, step=10, dwell=0, mode 2. Expect 10,20,30,20,10,20,…; `dir_down` rises on the cycle 20 follows 30 and falls on the cycle 20 follows 10.
- **Overflow guard:** cfg stop=0xFFFF, start=0xFFF0, step=0x20, mode 0. Expect a single point 0xFFF0, then `done`; no wrap to a low value.
- **Rejections:**
  - step=0, or start>stop, then `start`: expect `cfg_err` pulse, `busy` stays 0.
  - `cfg_valid` while busy: expect `cfg_ready=0` and stored config unchanged.
  - `cfg_valid` and `start` in the same cycle: expect the sweep to use the new config.
- **Reset mid-sweep:** assert `rst` asynchronously during DWELL. Expect outputs 0 immediately; after release, `frequency` tracks `manual_freq`.

Source files
------------

// File: rtl/awg_pkg.sv
// Shared AWG definitions: default widths, sweep mode codes and sequencer state encoding.
package awg_pkg;

  localparam int unsigned AWG_FREQ_W  = 16;
  localparam int unsigned AWG_DWELL_W = 16;

  // Code 3 is reserved and behaves as single-shot.
  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2
  } awg_state_e;

endpackage

// File: rtl/awg_dwell_timer.sv
// Loadable down-counter that stops at zero; expired flags the zero count.
module awg_dwell_timer
  import awg_pkg::*;
#(
  parameter int unsigned W = AWG_DWELL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/awg_sweep_sequencer.sv
// Frequency-sweep scheduler: passes manual_freq through when idle, otherwise
// steps start..stop with a per-point dwell in single, repeat or triangle shape.
module awg_sweep_sequencer
  import awg_pkg::*;
#(
  parameter int unsigned FREQ_W  = AWG_FREQ_W,
  parameter int unsigned DWELL_W = AWG_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_start,
  input  logic [FREQ_W-1:0]  cfg_stop,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  manual_freq,
  output logic [FREQ_W-1:0]  frequency,
  output logic               freq_update,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               dir_down
);

  awg_state_e         r_state;
  logic [FREQ_W-1:0]  r_start, r_stop, r_step, r_freq;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0]         r_mode;
  logic               r_freq_update, r_busy, r_done, r_cfg_err, r_dir_down, r_cfg_ready;

  logic               w_cfg_acc, w_start_ok, w_start_acc;
  logic [FREQ_W-1:0]  w_eff_start, w_eff_stop, w_eff_step;
  logic [DWELL_W-1:0] w_eff_dwell, w_load_dwell, w_timer_value;
  logic               w_timer_load, w_timer_expired, w_load_zero;
  logic [FREQ_W:0]    w_sum;
  logic               w_up_ok, w_dn_ok, w_end, w_next_dir;
  logic [FREQ_W-1:0]  w_diff, w_next_freq;

  // A same-cycle config write is validated and used by the start it accompanies.
  assign w_cfg_acc   = cfg_valid & r_cfg_ready;
  assign w_eff_start = w_cfg_acc ? cfg_start : r_start;
  assign w_eff_stop  = w_cfg_acc ? cfg_stop  : r_stop;
  assign w_eff_step  = w_cfg_acc ? cfg_step  : r_step;
  assign w_eff_dwell = w_cfg_acc ? cfg_dwell : r_dwell;
  assign w_start_ok  = (w_eff_start <= w_eff_stop) && (w_eff_step != '0);
  assign w_start_acc = (r_state == ST_IDLE) && start && w_start_ok;

  // The STEP cycle is one of the dwell+1 visible cycles, so the timer holds
  // dwell-1 and a zero dwell skips DWELL entirely.
  assign w_load_dwell  = (r_state == ST_IDLE) ? w_eff_dwell : r_dwell;
  assign w_load_zero   = (w_load_dwell == '0);
  assign w_timer_value = w_load_zero ? '0 : (w_load_dwell - DWELL_W'(1));
  assign w_timer_load  = w_start_acc || ((r_state == ST_STEP) && !abort && !w_end);

  awg_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_timer_load),
    .i_value   (w_timer_value),
    .o_expired (w_timer_expired)
  );

  // One extra bit keeps freq+step and start+step from wrapping.
  assign w_sum   = {1'b0, r_freq} + {1'b0, r_step};
  assign w_up_ok = (w_sum <= {1'b0, r_stop});
  assign w_dn_ok = ({1'b0, r_freq} >= ({1'b0, r_start} + {1'b0, r_step}));
  assign w_diff  = r_freq - r_step;

  always_comb begin
    w_next_freq = r_freq;
    w_next_dir  = r_dir_down;
    w_end       = 1'b0;
    if (!r_dir_down) begin
      if (w_up_ok) begin
        w_next_freq = w_sum[FREQ_W-1:0];
      end else if (r_mode == MODE_TRIANGLE) begin
        if (w_dn_ok) begin
          w_next_freq = w_diff;
          w_next_dir  = 1'b1;
        end
      end else if (r_mode == MODE_REPEAT) begin
        w_next_freq = r_start;
      end else begin
        w_end = 1'b1;
      end
    end else begin
      if (w_dn_ok) begin
        w_next_freq = w_diff;
      end else if (w_up_ok) begin
        w_next_freq = w_sum[FREQ_W-1:0];
        w_next_dir  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_start       <= '0;
      r_stop        <= '0;
      r_step        <= '0;
      r_dwell       <= '0;
      r_mode        <= '0;
      r_freq        <= '0;
      r_freq_update <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_dir_down    <= 1'b0;
      r_cfg_ready   <= 1'b0;
    end else begin
      r_freq_update <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_acc) begin
            r_start <= cfg_start;
            r_stop  <= cfg_stop;
            r_step  <= cfg_step;
            r_dwell <= cfg_dwell;
            r_mode  <= cfg_mode;
          end
          if (w_start_acc) begin
            r_freq        <= w_eff_start;
            r_freq_update <= 1'b1;
            r_dir_down    <= 1'b0;
            r_busy        <= 1'b1;
            r_cfg_ready   <= 1'b0;
            r_state       <= w_load_zero ? ST_STEP : ST_DWELL;
          end else begin
            r_freq      <= manual_freq;
            r_cfg_err   <= start;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end
        end
        ST_DWELL, ST_STEP: begin
          if (abort || ((r_state == ST_STEP) && w_end)) begin
            r_freq        <= manual_freq;
            r_freq_update <= 1'b1;
            r_done        <= !abort;
            r_dir_down    <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (r_state == ST_DWELL) begin
            if (w_timer_expired) r_state <= ST_STEP;
          end else begin
            r_freq        <= w_next_freq;
            r_dir_down    <= w_next_dir;
            r_freq_update <= 1'b1;
            r_state       <= w_load_zero ? ST_STEP : ST_DWELL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frequency   = r_freq;
  assign freq_update = r_freq_update;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;
  assign dir_down    = r_dir_down;
  assign cfg_ready   = r_cfg_ready;

endmodule

// File: tb/tb_awg_sweep_sequencer.sv
// Self-checking bench for awg_sweep_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a point/hold-count reference model.
module tb_awg_sweep_sequencer;

  localparam int unsigned FW = 16;
  localparam int unsigned DW = 16;

  logic          clk, rst;
  logic          cfg_valid, cfg_ready, start, abort;
  logic [FW-1:0] cfg_start, cfg_stop, cfg_step, manual_freq, frequency;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic          freq_update, busy, done, cfg_err, dir_down;

  awg_sweep_sequencer #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .start(start), .abort(abort),
    .manual_freq(manual_freq), .frequency(frequency), .freq_update(freq_update),
    .busy(busy), .done(done), .cfg_err(cfg_err), .dir_down(dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current point, remaining visible cycles, direction.
  int m_freq, m_hold, m_busy, m_dir, m_ready, m_upd, m_done, m_err;
  int s_start, s_stop, s_step, s_dwell, s_mode;
  int cnt_upd, cnt_done, cnt_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_freq = 0; m_hold = 0; m_busy = 0; m_dir = 0; m_ready = 0;
    m_upd = 0; m_done = 0; m_err = 0;
    s_start = 0; s_stop = 0; s_step = 0; s_dwell = 0; s_mode = 0;
  endtask

  task automatic model_advance();
    m_upd  = 1;
    m_hold = s_dwell + 1;
    if (m_dir == 0) begin
      if (m_freq + s_step <= s_stop) m_freq = m_freq + s_step;
      else if (s_mode == 2) begin
        if (m_freq - s_step >= s_start) begin m_dir = 1; m_freq = m_freq - s_step; end
      end else if (s_mode == 1) m_freq = s_start;
      else begin m_busy = 0; m_done = 1; m_dir = 0; m_freq = int'(manual_freq); end
    end else begin
      if (m_freq - s_step >= s_start) m_freq = m_freq - s_step;
      else if (m_freq + s_step <= s_stop) begin m_dir = 0; m_freq = m_freq + s_step; end
    end
  endtask

  task automatic model_edge();
    m_upd = 0; m_done = 0; m_err = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy == 0) begin
        if (cfg_valid && m_ready != 0) begin
          s_start = int'(cfg_start); s_stop = int'(cfg_stop); s_step = int'(cfg_step);
          s_dwell = int'(cfg_dwell); s_mode = int'(cfg_mode);
        end
        if (start && s_start <= s_stop && s_step != 0) begin
          m_busy = 1; m_freq = s_start; m_hold = s_dwell + 1; m_dir = 0; m_upd = 1;
        end else begin
          m_err  = start ? 1 : 0;
          m_freq = int'(manual_freq);
        end
      end else if (abort) begin
        m_busy = 0; m_freq = int'(manual_freq); m_upd = 1; m_dir = 0;
      end else begin
        m_hold--;
        if (m_hold == 0) model_advance();
      end
      m_ready = (m_busy == 0) ? 1 : 0;
    end
  endtask

  task automatic compare_all();
    check_eq("frequency",   32'(frequency),   32'(m_freq));
    check_eq("freq_update", 32'(freq_update), 32'(m_upd));
    check_eq("busy",        32'(busy),        32'(m_busy));
    check_eq("done",        32'(done),        32'(m_done));
    check_eq("cfg_err",     32'(cfg_err),     32'(m_err));
    check_eq("dir_down",    32'(dir_down),    32'(m_dir));
    check_eq("cfg_ready",   32'(cfg_ready),   32'(m_ready));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cnt_upd  += int'(freq_update);
    cnt_done += int'(done);
    cnt_err  += int'(cfg_err);
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int dw, input int md);
    cfg_start = FW'(s); cfg_stop = FW'(e); cfg_step = FW'(st);
    cfg_dwell = DW'(dw); cfg_mode = 2'(md);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    cnt_upd = 0; cnt_done = 0; cnt_err = 0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    manual_freq = 16'h1234;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    run(2);
    rst = 1'b0;
    run(2);

    // Single-shot sweep 100..130 step 10, three cycles per point.
    clear_counts();
    set_cfg(100, 130, 10, 2, 0); cfg_valid = 1'b1; tick();
    start = 1'b1; run(16);
    check_eq("single_upd_count",  32'(cnt_upd),  32'd5);
    check_eq("single_done_count", 32'(cnt_done), 32'd1);

    // Repeat sawtooth with config and start in the same cycle.
    clear_counts();
    set_cfg(0, 20, 10, 0, 1); cfg_valid = 1'b1; start = 1'b1; run(9);
    set_cfg(500, 900, 7, 3, 2); cfg_valid = 1'b1; start = 1'b1; run(4);
    manual_freq = 16'h0777; abort = 1'b1; run(3);
    check_eq("repeat_done_count", 32'(cnt_done), 32'd0);
    start = 1'b1; run(5); abort = 1'b1; run(2);

    // Triangle, then a degenerate triangle that cannot move.
    set_cfg(10, 30, 10, 0, 2); cfg_valid = 1'b1; tick();
    start = 1'b1; run(12); abort = 1'b1; run(2);
    set_cfg(50, 50, 5, 1, 2); cfg_valid = 1'b1; start = 1'b1; run(8);
    abort = 1'b1; run(2);

    // Overflow guard near the top of the range.
    clear_counts();
    set_cfg(16'hFFF0, 16'hFFFF, 16'h20, 1, 0); cfg_valid = 1'b1; start = 1'b1; run(6);
    check_eq("overflow_done_count", 32'(cnt_done), 32'd1);

    // Rejected starts.
    clear_counts();
    set_cfg(10, 20, 0, 0, 0); cfg_valid = 1'b1; start = 1'b1; run(2);
    set_cfg(30, 20, 1, 0, 0); cfg_valid = 1'b1; start = 1'b1; run(2);
    check_eq("reject_err_count", 32'(cnt_err), 32'd2);

    // Asynchronous reset during DWELL.
    set_cfg(1000, 2000, 1, 5, 1); cfg_valid = 1'b1; start = 1'b1; run(3);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    tick();
    rst = 1'b0; manual_freq = 16'h0042;
    run(3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) manual_freq = FW'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) begin
        int s, e;
        s = int'($urandom_range(0, 65535));
        e = s + int'($urandom_range(0, 120));
        if (e > 65535) e = 65535;
        if ($urandom_range(0, 7) == 0) begin int t; t = s; s = e + 1; e = t; end
        if (s > 65535) s = 65535;
        set_cfg(s, e, int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
        cfg_valid = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) start = 1'b1;
      if ($urandom_range(0, 39) == 0) abort = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
